fetch_unit: RTL and testbench

- Fetch-stage producer for the IF/ID pipeline register. It holds the PC and fetches one instruction at a time from instruction memory (or the icache front) over a req/ready + rvalid handshake.
- It presents InstrF, PCF and PC_plus_4F to the decode register and honours stall (StallF) and branch/jump redirect (PCSrcE) from the hazard and execute stages.
- It raises FetchStallF while no instruction is ready. The hazard unit uses this to clear the decode register (bubble).

---
 rtl/fetch_unit.sv | 80 ++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: IF-stage PC register and one-outstanding imem fetch FSM feeding the IF/ID register.
// Define FETCH_PERF_EN to add the fetch_count_o / stall_cycles_o performance counters.
module fetch_unit #(
    parameter int DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StallF,
    input  logic                  PCSrcE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] InstrF,
    output logic [DATA_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0] PC_plus_4F,
    output logic                  InstrValidF,
    output logic                  FetchStallF
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           fetch_count_o,
    output logic [31:0]           stall_cycles_o
`endif
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN, S_HOLD} state_t;

    state_t                  state, next_state;
    logic [DATA_WIDTH-1:0]   pc, hold, target;
    logic                    accept, capture, consume;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S_REQ;
        else     state <= next_state;

    // DRAIN swallows the one response still owed for a request the redirect made stale
    always_comb begin
        accept     = imem_req && imem_ready;
        next_state = state == S_REQ   ? (accept ? (PCSrcE ? S_DRAIN : S_WAIT) : S_REQ)
                   : state == S_WAIT  ? (imem_rvalid ? (PCSrcE ? S_REQ : S_HOLD) : (PCSrcE ? S_DRAIN : S_WAIT))
                   : state == S_DRAIN ? (imem_rvalid ? S_REQ : S_DRAIN)
                   : (PCSrcE || !StallF) ? S_REQ : S_HOLD;
    end

    always_comb begin
        imem_req    = state == S_REQ && !rst;
        imem_addr   = pc;
        PCF         = pc;
        PC_plus_4F  = pc + DATA_WIDTH'(4);
        InstrValidF = state == S_HOLD;
        InstrF      = InstrValidF ? hold : '0;
        FetchStallF = !InstrValidF;
        target      = PCTargetE & ~DATA_WIDTH'(3);
        capture     = state == S_WAIT && imem_rvalid && !PCSrcE;
        consume     = state == S_HOLD && !StallF && !PCSrcE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pc   <= RESET_PC;
            hold <= '0;
        end else begin
            if (PCSrcE)       pc <= target;
            else if (consume) pc <= PC_plus_4F;
            if (capture)      hold <= imem_rdata;
        end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            fetch_count_o  <= '0;
            stall_cycles_o <= '0;
        end else begin
            if (consume)     fetch_count_o  <= fetch_count_o + 32'd1;
            if (FetchStallF) stall_cycles_o <= stall_cycles_o + 32'd1;
        end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, reset/wrap sequences and a randomized run against a
// transaction-level fetch model (architectural PC, one outstanding request, stale-response rule).
module tb_fetch_unit;
    logic        clk = 0, rst, StallF, PCSrcE, imem_ready, imem_rvalid;
    logic        imem_req, InstrValidF, FetchStallF;
    logic [31:0] PCTargetE, imem_rdata, imem_addr, InstrF, PCF, PC_plus_4F;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_o, stall_cycles_o;
`endif

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .InstrF(InstrF), .PCF(PCF),
        .PC_plus_4F(PC_plus_4F), .InstrValidF(InstrValidF), .FetchStallF(FetchStallF)
`ifdef FETCH_PERF_EN
        , .fetch_count_o(fetch_count_o), .stall_cycles_o(stall_cycles_o)
`endif
    );

    typedef struct {
        logic        st, sr;
        logic [31:0] tg;
        logic        rd;
        int          lt;
        logic        er, ev;
        logic [31:0] epc, ein;
    } vec_t;

    vec_t        tab[26];
    int          total = 0, bad = 0, consumed = 0;
    logic        m_pend = 0, m_resp = 0;
    int          m_lat = 0;
    logic [31:0] m_addr = 0;
    logic        e_pend, e_fresh, e_valid;
    logic [31:0] e_pc;
    bit          stray_en = 0, use_model = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a == 0 ? 32'h00500093 : a == 4 ? 32'h00100113 : {a[15:0] ^ 16'h5a5a, a[31:16]};
    endfunction

    function automatic vec_t mk(input logic st, sr, input logic [31:0] tg, input logic rd,
                                input int lt, input logic er, ev, input logic [31:0] epc);
        vec_t v;
        v.st = st; v.sr = sr; v.tg = tg; v.rd = rd; v.lt = lt;
        v.er = er; v.ev = ev; v.epc = epc; v.ein = ev ? mem(epc) : 32'h0;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic chkb(input string n, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", n, act, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1;
        e_pc = 0; e_valid = 0; e_pend = 0; e_fresh = 0;
        #1;
        chk("rst_pcf", PCF, 32'h0);
        chk("rst_instr", InstrF, 32'h0);
        chkb("rst_req", imem_req, 1'b0);
        chkb("rst_valid", InstrValidF, 1'b0);
        chkb("rst_fstall", FetchStallF, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic drive(input logic st, sr, input logic [31:0] tg, input logic rd);
        StallF = st; PCSrcE = sr; PCTargetE = tg; imem_ready = rd;
        m_resp = m_pend && m_lat == 0;
        if (m_resp) begin
            imem_rvalid = 1; imem_rdata = mem(m_addr);
        end else if (stray_en && !m_pend && $urandom_range(0, 3) == 0) begin
            imem_rvalid = 1; imem_rdata = $urandom;
        end else begin
            imem_rvalid = 0; imem_rdata = $urandom;
        end
        #3;
    endtask

    task automatic model_check;
        logic er = !e_valid && !e_pend;
        chkb("req", imem_req, er);
        chkb("valid", InstrValidF, e_valid);
        chk("pcf", PCF, e_pc);
        chk("addr", imem_addr, e_pc);
        chk("instr", InstrF, e_valid ? mem(e_pc) : 32'h0);
        chk("pc4", PC_plus_4F, e_pc + 32'd4);
        chkb("fstall", FetchStallF, !e_valid);
    endtask

    // Memory side follows the DUT's request; the model side follows only the fetch rules.
    task automatic finish_cycle(input int lt);
        logic        er = !e_valid && !e_pend;
        logic        nv = e_valid;
        logic [31:0] npc = e_pc;
        if (m_resp) m_pend = 0;
        if (imem_req && imem_ready) begin
            m_pend = 1; m_addr = imem_addr; m_lat = lt;
        end else if (m_pend) m_lat--;
        if (imem_rvalid && e_pend) begin
            e_pend = 0;
            if (e_fresh && !PCSrcE) nv = 1;
        end
        if (er && imem_ready) begin
            e_pend = 1; e_fresh = !PCSrcE;
        end else if (PCSrcE) e_fresh = 0;
        if (PCSrcE) begin
            npc = PCTargetE & ~32'h3; nv = 0;
        end else if (e_valid && !StallF) begin
            npc = e_pc + 32'd4; nv = 0; consumed++;
        end
        e_valid = nv; e_pc = npc;
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic st, sr, input logic [31:0] tg, input logic rd, input int lt);
        drive(st, sr, tg, rd);
        if (use_model) model_check();
        finish_cycle(lt);
    endtask

    initial begin
        rst = 1; StallF = 0; PCSrcE = 0; PCTargetE = 0; imem_ready = 0;
        imem_rvalid = 0; imem_rdata = 0;
        tab[0]  = mk(0, 0, 0, 1, 0, 1, 0, 32'h0);
        tab[1]  = mk(0, 0, 0, 1, 0, 0, 0, 32'h0);
        tab[2]  = mk(0, 0, 0, 1, 0, 0, 1, 32'h0);
        tab[3]  = mk(0, 0, 0, 1, 0, 1, 0, 32'h4);
        tab[4]  = mk(0, 0, 0, 1, 0, 0, 0, 32'h4);
        tab[5]  = mk(0, 0, 0, 1, 0, 0, 1, 32'h4);
        tab[6]  = mk(0, 0, 0, 1, 0, 1, 0, 32'h8);
        tab[7]  = mk(0, 0, 0, 1, 0, 0, 0, 32'h8);
        for (int i = 8; i <= 12; i++) tab[i] = mk(1, 0, 0, 1, 0, 0, 1, 32'h8);
        tab[13] = mk(0, 0, 0, 1, 0, 0, 1, 32'h8);
        tab[14] = mk(0, 0, 0, 1, 1, 1, 0, 32'hC);
        tab[15] = mk(0, 1, 32'h103, 1, 0, 0, 0, 32'hC);
        tab[16] = mk(0, 0, 0, 1, 0, 0, 0, 32'h100);
        tab[17] = mk(0, 0, 0, 1, 0, 1, 0, 32'h100);
        tab[18] = mk(0, 0, 0, 1, 0, 0, 0, 32'h100);
        tab[19] = mk(1, 1, 32'h200, 1, 0, 0, 1, 32'h100);
        for (int i = 20; i <= 23; i++) tab[i] = mk(0, 0, 0, 0, 0, 1, 0, 32'h200);
        tab[24] = mk(0, 0, 0, 1, 2, 1, 0, 32'h200);
        tab[25] = mk(0, 0, 0, 1, 0, 0, 0, 32'h200);

        do_reset();
        for (int i = 0; i < 26; i++) begin
            drive(tab[i].st, tab[i].sr, tab[i].tg, tab[i].rd);
            chkb($sformatf("row%0d_req", i), imem_req, tab[i].er);
            chkb($sformatf("row%0d_valid", i), InstrValidF, tab[i].ev);
            chk($sformatf("row%0d_pcf", i), PCF, tab[i].epc);
            chk($sformatf("row%0d_addr", i), imem_addr, tab[i].epc);
            chk($sformatf("row%0d_instr", i), InstrF, tab[i].ein);
            chk($sformatf("row%0d_pc4", i), PC_plus_4F, tab[i].epc + 32'd4);
            chkb($sformatf("row%0d_fstall", i), FetchStallF, !tab[i].ev);
            finish_cycle(tab[i].lt);
        end

        // reset lands mid-WAIT; the owed response then arrives while in REQ and must be ignored
        #2;
        do_reset();
        use_model = 1;
        repeat (3) cycle(0, 0, 0, 0, 0);

        cycle(0, 1, 32'hFFFF_FFFF, 0, 0);
        chk("wrap_pcf", PCF, 32'hFFFF_FFFC);
        chk("wrap_pc4", PC_plus_4F, 32'h0);
        repeat (3) cycle(0, 0, 0, 1, 0);
        chk("wrap_next_pcf", PCF, 32'h0);

        do_reset();
        stray_en = 1;
        consumed = 0;
        repeat (1500)
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 7) == 0 ? 32'hFFFF_FFFD : $urandom,
                  $urandom_range(0, 3) != 0, int'($urandom_range(0, 2)));
        chkb("liveness", consumed >= 50, 1'b1);

`ifdef FETCH_PERF_EN
        stray_en = 0;
        m_pend = 0;
        do_reset();
        repeat (30) cycle(0, 0, 0, 1, 0);
        chk("perf_fetch", fetch_count_o, 32'd10);
        chk("perf_stall", stall_cycles_o, 32'd20);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
